rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Shares one synchronous ROM instance (1-cycle registered read, `q` tri-stated when not enabled) between `NUM_REQ` requesters, e.g. the MSX slot read path and the shadow-copy/checksum engine. It sits directly in front of the ROM, drives its `address`/`enable`, and returns captured read data to the granted requester with a per-port valid pulse. One ROM access is issued per clock at most. Requests are pipelined so back-to-back accesses from different ports run at full rate.

## Interface
- `ADDR_WIDTH`, 14: ROM address width; must match the ROM instance.
- `DATA_WIDTH`, 8: ROM data width.
- `NUM_REQ`, 2: number of requesters; legal range 2..4.

Ports:
- `clock`  in  1: single clock, shared with the ROM.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req`  in  NUM_REQ: per-port request level.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH: packed per-port address. Port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH]. Must be held stable while `req[k]` is high and not yet granted.
- `gnt`  out  NUM_REQ: one-hot, one-cycle grant pulse.
- `rdata`  out  DATA_WIDTH: last captured ROM word, shared by all ports.
- `rvalid`  out  NUM_REQ: one-hot, one-cycle pulse marking `rdata` valid for port k.
- `rom_address`  out  ADDR_WIDTH: connects to ROM `address`.
- `rom_enable`  out  1: connects to ROM `enable`.
- `rom_q`  in  DATA_WIDTH: connects to ROM `q`.

## Operation
- Three-stage pipeline: ARB → ROM → CAPTURE. No FSM beyond per-stage valid bits and port tags.
- **ARB stage**, at each edge:
  - The eligible set is `req` minus the port granted on the previous edge. This mask prevents a double grant while the requester reacts to `gnt`.
  - If the set is non-empty, pick the winner, register `rom_address` from the winner's `req_addr`, set `rom_enable`=1, pulse `gnt[winner]`, and push its tag into stage 2.
  - If the set is empty, `rom_enable`=0. `rom_address` holds its last value.
- **ROM stage**: the tag advances one edge, matching the ROM's registered read.
- **CAPTURE stage**:
  - If the stage-2 tag is valid, `rdata` <= `rom_q` and `rvalid[tag]` pulses.
  - Otherwise `rdata` holds and `rom_q` is ignored, since it is Z when not enabled.
- **Round-robin (default)**: a pointer starts at port 0. After each grant it moves to winner+1 mod `NUM_REQ`. Search begins at the pointer.
- **Requester protocol**:
  - On seeing `gnt[k]`, the requester may drop `req[k]` or change `req_addr` for its next access.
  - A continuously requesting port is granted at most every 2nd cycle. Any other port fills the gap.
- **Reset**:
  - All outputs go to 0: `gnt`, `rvalid`, `rdata`, `rom_address`, `rom_enable`.
  - The pointer goes to 0, all pipeline valids clear, and the mask clears.
- **Reset mid-operation**: in-flight accesses are dropped with no `rvalid`. Requesters re-request after reset.
- **Simultaneous events**: a new grant, an in-flight ROM read and a capture can all occur in the same cycle. There are no structural stalls and no backpressure on `rvalid`.

## Timing
- Edge E0: request sampled; `gnt` and `rom_enable` are high during cycle E0→E1.
- Edge E1: ROM registers `q`.
- Edge E2: `rdata` captured; `rvalid` high during cycle E2→E3.
- Request-to-rvalid latency is 3 edges. Throughput is 1 word per cycle aggregate.
- `gnt`, `rvalid`, `rdata`, `rom_address` and `rom_enable` are all registered. There is no combinational path from `req` to any output.

## Configuration
- `ROM_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest port index wins. The pointer logic is removed. The previous-grant mask still applies, so port 0 cannot starve port 1 completely.
  - Undefined: round-robin as above.

## Structure
- Package `rom_arb_pkg`:
  - `ROM_ARB_LATENCY` = 3.
  - `MAX_REQ` = 4.
  - Typedef `rom_arb_tag_t`: a valid bit plus a 2-bit port index.
- Sub-module `rom_arb_pick`: a combinational rotate-priority picker. Inputs are the eligible vector and pointer; outputs are winner index and any-valid. In fixed-priority mode the pointer is tied to 0.

## Test plan
- **Reset then single request**: port 0 requests addr 0x0010 (ROM preloaded mem[0x10]=0xA5) → `gnt[0]` at E0, `rvalid[0]` and `rdata`=0xA5 at E2; all outputs 0 during reset.
- **Two simultaneous requests, round-robin**: port 0 reads 0x0001 (=0x11), port 1 reads 0x0002 (=0x22), both held high → grants alternate 0,1,0,1; `rvalid` alternates with matching data; one `rvalid` per cycle.
- **Single port held high**: port 1 keeps `req` high with incrementing address after each `gnt` → grants every 2nd cycle, never on consecutive edges.
- **`ROM_ARB_FIXED_PRIO_EN` defined**: ports 0 and 1 request continuously → pattern 0,1,0,1, caused by the mask; with 3 ports, port 2 is never granted while 0 and 1 are both requesting.
- **Reset mid-flight**: assert `reset_n`=0 one cycle after `gnt` → no `rvalid`; after release, first grant goes to port 0.
- **Idle**: no requests for 10 cycles → `rom_enable`=0, `rdata` unchanged, no `rvalid` despite Z on `rom_q`.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared constants and types for the ROM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: pipeline depth, maximum requester count, pipeline tag type and
// a one-hot helper used for the grant and read-valid vectors.
package rom_arb_pkg;

    // Edges from request sample to rvalid.
    localparam int ROM_ARB_LATENCY = 3;
    // Widest configuration supported by the 2-bit port tag.
    localparam int MAX_REQ = 4;

    // Tag that travels alongside a ROM access through the pipeline.
    typedef struct packed {
        logic       vld;
        logic [1:0] port;
    } rom_arb_tag_t;

    function automatic logic [MAX_REQ-1:0] port_onehot(input logic [1:0] port);
        return MAX_REQ'(1) << port;
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side bus of the ROM arbiter: request levels, addresses, grants, read data.
// Latency: n/a (wiring only).
// Backpressure: none; gnt/rvalid are one-cycle pulses that must be consumed.
//
// Signals: req / req_addr (requesters -> arbiter), gnt / rdata / rvalid
// (arbiter -> requesters). Port k's address is req_addr[k*ADDR_WIDTH +: ADDR_WIDTH].
// Modports: master = requester side, slave = arbiter side.
interface rom_arbiter_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            gnt;
    logic [DATA_WIDTH-1:0]         rdata;
    logic [NUM_REQ-1:0]            rvalid;

    modport master (output req, output req_addr, input gnt, input rdata, input rvalid);
    modport slave  (input req, input req_addr, output gnt, output rdata, output rvalid);
endinterface

// File: rtl/rom_arb_pick.sv
// Rotating-priority picker: first eligible port at or after the pointer wins.
// Latency: combinational.
// Backpressure: none.
//
// Ports: i_eligible (candidate vector), i_ptr (search start),
//        o_winner (index of winner), o_any (at least one candidate).
module rom_arb_pick
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic [1:0]         i_ptr,
    output logic [1:0]         o_winner,
    output logic               o_any
);

    logic [2:0] w_idx;

    // Walk the search order from the far end back to the pointer so that the
    // last hit written is the one closest to the pointer.
    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = {1'b0, i_ptr} + 3'(i);
            if (w_idx >= 3'(NUM_REQ)) begin
                w_idx = w_idx - 3'(NUM_REQ);
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (w_idx == 3'(k) && i_eligible[k]) begin
                    o_winner = 2'(k);
                    o_any    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one registered-read ROM among NUM_REQ requesters, one access per clock.
// Latency: request sampled at E0, gnt during E0->E1, rdata/rvalid during E2->E3.
// Backpressure: none; a port is masked for one edge after its grant, rvalid cannot stall.
//
// Ports: clock, reset_n (async, active low); bus (rom_arbiter_if slave:
// req/req_addr in, gnt/rdata/rvalid out); rom_address/rom_enable to the ROM,
// rom_q from the ROM (high-Z when the ROM was not enabled).
// Build option: define ROM_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins); otherwise round-robin from a pointer that follows the last winner.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    rom_arbiter_if.slave          bus,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic                  rom_enable,
    input  logic [DATA_WIDTH-1:0] rom_q
);

    logic [NUM_REQ-1:0]    r_gnt;
    logic [NUM_REQ-1:0]    r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] r_rom_address;
    logic                  r_rom_enable;
    rom_arb_tag_t          r_arb_tag;   // access presented to the ROM this cycle
    rom_arb_tag_t          r_rom_tag;   // ROM has registered q for this access

    logic [NUM_REQ-1:0]    w_eligible;
    logic [1:0]            w_ptr;
    logic [1:0]            w_winner;
    logic                  w_any;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [MAX_REQ-1:0]    w_win_oh;
    logic [MAX_REQ-1:0]    w_tag_oh;

    // r_gnt is exactly the port granted on the previous edge, so it doubles as
    // the mask that stops a second grant before the requester sees the first.
    assign w_eligible = bus.req & ~r_gnt;

`ifdef ROM_ARB_FIXED_PRIO_EN
    assign w_ptr = 2'd0;
`else
    logic [1:0] r_ptr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= 2'd0;
        end else if (w_any) begin
            r_ptr <= (w_winner == 2'(NUM_REQ - 1)) ? 2'd0 : w_winner + 2'd1;
        end
    end

    assign w_ptr = r_ptr;
`endif

    rom_arb_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_eligible (w_eligible),
        .i_ptr      (w_ptr),
        .o_winner   (w_winner),
        .o_any      (w_any)
    );

    always_comb begin
        w_win_addr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_winner == 2'(k)) begin
                w_win_addr = bus.req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign w_win_oh = port_onehot(w_winner);
    assign w_tag_oh = port_onehot(r_rom_tag.port);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_gnt         <= '0;
            r_rvalid      <= '0;
            r_rdata       <= '0;
            r_rom_address <= '0;
            r_rom_enable  <= 1'b0;
            r_arb_tag     <= '0;
            r_rom_tag     <= '0;
        end else begin
            // ARB stage
            r_gnt          <= w_any ? w_win_oh[NUM_REQ-1:0] : '0;
            r_rom_enable   <= w_any;
            r_arb_tag.vld  <= w_any;
            r_arb_tag.port <= w_winner;
            if (w_any) begin
                r_rom_address <= w_win_addr;
            end

            // ROM stage: tag tracks the ROM's own output register
            r_rom_tag <= r_arb_tag;

            // CAPTURE stage: rom_q is only meaningful behind a valid tag
            if (r_rom_tag.vld) begin
                r_rdata  <= rom_q;
                r_rvalid <= w_tag_oh[NUM_REQ-1:0];
            end else begin
                r_rvalid <= '0;
            end
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.rvalid  = r_rvalid;
    assign bus.rdata   = r_rdata;
    assign rom_address = r_rom_address;
    assign rom_enable  = r_rom_enable;

endmodule

// File: tb/tb_rom_arbiter.sv
// Testbench for rom_arbiter with three requesters and a behavioural ROM.
// Latency: n/a.
// Backpressure: n/a.
module tb_rom_arbiter;
    import rom_arb_pkg::*;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int NR = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    rom_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    logic [AW-1:0] rom_address;
    logic          rom_enable;
    wire  [DW-1:0] rom_q;

    rom_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .rom_address (rom_address),
        .rom_enable  (rom_enable),
        .rom_q       (rom_q)
    );

    // ROM contents
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        case (a)
            14'h0010: return 8'hA5;
            14'h0001: return 8'h11;
            14'h0002: return 8'h22;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Behavioural ROM: registered read, q floats when the last cycle was not enabled
    logic [DW-1:0] rom_q_r;
    logic          rom_drv = 1'b0;
    always @(posedge clock) begin
        rom_drv <= rom_enable;
        if (rom_enable) rom_q_r <= rom_word(rom_address);
    end
    assign rom_q = rom_drv ? rom_q_r : 'z;

    // Scoreboard
    typedef struct { int port; logic [AW-1:0] addr; } gexp_t;
    typedef struct { int port; logic [DW-1:0] data; } rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];
    int    gcyc[$];
    int    takes1[$];
    int    nvec = 0;
    int    nfail = 0;
    int    cyc = 0;
    int    stepno = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant or read data
    logic [NR-1:0] prev_gnt = '0;
    initial begin
        gexp_t g;
        rexp_t r;
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset_n) begin
                gcyc.delete();
                prev_gnt = '0;
            end else begin
                if (bus.gnt != '0) begin
                    chk("gnt_back_to_back", 32'((bus.gnt & prev_gnt) != '0), 32'd0);
                    if (gq.size() == 0) begin
                        chk("gnt_unexpected", 32'(bus.gnt), 32'd0);
                    end else begin
                        g = gq.pop_front();
                        chk("gnt_port", 32'(bus.gnt), 32'(1) << g.port);
                        chk("gnt_addr", 32'(rom_address), 32'(g.addr));
                        chk("gnt_rom_enable", 32'(rom_enable), 32'd1);
                    end
                    gcyc.push_back(cyc);
                end
                if (bus.rvalid != '0) begin
                    if (rq.size() == 0) begin
                        chk("rvalid_unexpected", 32'(bus.rvalid), 32'd0);
                    end else begin
                        r = rq.pop_front();
                        chk("rvalid_port", 32'(bus.rvalid), 32'(1) << r.port);
                        chk("rdata", 32'(bus.rdata), 32'(r.data));
                    end
                    if (gcyc.size() != 0)
                        chk("latency", 32'(cyc - gcyc.pop_front()), 32'(ROM_ARB_LATENCY - 1));
                end
                prev_gnt = bus.gnt;
            end
        end
    end

    // Requester model: cnt accesses left, address held until granted
    int            cnt[NR];
    logic [AW-1:0] ad[NR];
    bit            inc[NR];

    task automatic step();
        logic [NR-1:0] taken;
        @(posedge clock);
        #1;
        taken = bus.req & bus.gnt;
        for (int k = 0; k < NR; k++) begin
            if (((taken >> k) & 3'b001) != 3'b000) begin
                cnt[k]--;
                if (inc[k]) ad[k]++;
                if (k == 1) takes1.push_back(stepno);
            end
            if (!reset_n) cnt[k] = 0;
        end
        stepno++;
        bus.req      = {cnt[2] > 0, cnt[1] > 0, cnt[0] > 0};
        bus.req_addr = {ad[2], ad[1], ad[0]};
    endtask

    task automatic setreq(input int k, input int n, input logic [AW-1:0] a, input bit i);
        cnt[k] = n;
        ad[k]  = a;
        inc[k] = i;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((gq.size() != 0 || rq.size() != 0 || cnt[0] != 0 || cnt[1] != 0 || cnt[2] != 0) && n < 60) begin
            step();
            n++;
        end
        chk(nm, 32'(n < 60), 32'd1);
        repeat (3) step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        @(negedge clock);
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
        chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
        chk({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
        chk({tag, "_rom_address"}, 32'(rom_address), 32'd0);
        chk({tag, "_rom_enable"}, 32'(rom_enable), 32'd0);
    endtask

    initial begin
        int first;
        int p;
        int n;
        int seq5[9];
        bit seen;
        bus.req = '0;
        bus.req_addr = '0;
        for (int k = 0; k < NR; k++) setreq(k, 0, '0, 1'b0);

        // Reset state
        repeat (2) @(negedge clock);
        chk_reset_outputs("reset");
        @(posedge clock); #1 reset_n = 1'b1;
        repeat (2) step();

        // Single request from port 0
        gq.push_back('{0, 14'h0010});
        rq.push_back('{0, 8'hA5});
        setreq(0, 1, 14'h0010, 1'b0);
        drain("single_drain");

        // Ports 0 and 1 together; pointer sits at 1 after the previous grant
`ifdef ROM_ARB_FIXED_PRIO_EN
        first = 0;
`else
        first = 1;
`endif
        for (int i = 0; i < 8; i++) begin
            p = (i % 2 == 0) ? first : 1 - first;
            gq.push_back('{p, (p == 0) ? 14'h0001 : 14'h0002});
            rq.push_back('{p, (p == 0) ? 8'h11 : 8'h22});
        end
        setreq(0, 4, 14'h0001, 1'b0);
        setreq(1, 4, 14'h0002, 1'b0);
        drain("pair_drain");

        // Port 1 alone, incrementing address: grant every second edge
        takes1.delete();
        for (int i = 0; i < 5; i++) begin
            gq.push_back('{1, 14'(14'h0100 + i)});
            rq.push_back('{1, rom_word(14'(14'h0100 + i))});
        end
        setreq(1, 5, 14'h0100, 1'b1);
        drain("solo_drain");
        chk("solo_grant_count", 32'(takes1.size()), 32'd5);
        for (int i = 1; i < takes1.size(); i++)
            chk("solo_grant_gap", 32'(takes1[i] - takes1[i-1]), 32'd2);

        // All three ports, three accesses each
`ifdef ROM_ARB_FIXED_PRIO_EN
        seq5 = '{0, 1, 0, 1, 0, 1, 2, 2, 2};
`else
        seq5 = '{2, 0, 1, 2, 0, 1, 2, 0, 1};
`endif
        for (int i = 0; i < 9; i++) begin
            gq.push_back('{seq5[i], 14'(14'h0020 + seq5[i])});
            rq.push_back('{seq5[i], rom_word(14'(14'h0020 + seq5[i]))});
        end
        for (int k = 0; k < NR; k++) setreq(k, 3, 14'(14'h0020 + k), 1'b0);
        drain("triple_drain");

        // Reset one cycle after a grant: the access must vanish
        gq.push_back('{0, 14'h0010});
        setreq(0, 1, 14'h0010, 1'b0);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 10) begin
            step();
            seen = bus.gnt[0];
            n++;
        end
        chk("midflight_gnt_seen", 32'(seen), 32'd1);
        @(posedge clock); #1 reset_n = 1'b0;
        chk_reset_outputs("midreset");
        repeat (3) step();
        @(posedge clock); #1 reset_n = 1'b1;
        repeat (2) step();
        chk("midflight_queue_empty", 32'(gq.size() + rq.size()), 32'd0);

        // After reset the pointer is back at port 0
        gq.push_back('{0, 14'h0010});
        gq.push_back('{1, 14'h0002});
        rq.push_back('{0, 8'hA5});
        rq.push_back('{1, 8'h22});
        setreq(0, 1, 14'h0010, 1'b0);
        setreq(1, 1, 14'h0002, 1'b0);
        drain("postreset_drain");

        // Idle: nothing enabled, rdata holds despite a floating rom_q
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("idle_rom_enable", 32'(rom_enable), 32'd0);
            chk("idle_rvalid", 32'(bus.rvalid), 32'd0);
            chk("idle_rdata", 32'(bus.rdata), 32'h22);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors applied", nvec);
        $fatal(1, "watchdog");
    end

endmodule
